fifo_arbiter_ctrl: RTL and testbench
====================================

# fifo_arbiter_ctrl

Round-robin arbiter and sequencer for the interconnect's four input FIFOs and four output FIFOs. It programs the almost-full and almost-empty thresholds of all FIFOs. It pops one word at a time from a non-empty input FIFO and routes the word to the output FIFO selected by the word's two MSBs. Popping is throttled by downstream almost-full back-pressure, and the block halts on any FIFO error.

## Interface
- WORD_SIZE, 6, data word width; bits [WORD_SIZE-1:WORD_SIZE-2] are the destination index
- PTR_L, 5, threshold width, matching the FIFO counter width
- MEM_SIZE, 4, FIFO depth; legal almost-full threshold ≤ MEM_SIZE-2

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  requests threshold programming
- umbral_full_in  in  PTR_L  almost-full threshold to program
- umbral_empty_in  in  PTR_L  almost-empty threshold to program
- in_empty  in  4  empty flags of input FIFOs 0..3
- in_data0..in_data3  in  WORD_SIZE each  read data of input FIFOs; valid the cycle after the pop
- out_almost_full  in  4  almost-full flags of output FIFOs 0..3
- fifo_error  in  8  error flags; [3:0] are the input FIFOs, [7:4] the output FIFOs
- full_threshold  out  PTR_L  almost-full threshold driven to all FIFOs
- empty_threshold  out  PTR_L  almost-empty threshold driven to all FIFOs
- in_pop  out  4  one-hot-or-zero pop strobe to the input FIFOs (registered)
- out_push  out  4  one-hot-or-zero push strobe to the output FIFOs (registered)
- out_data  out  WORD_SIZE  word presented with out_push (registered)
- state  out  5  one-hot state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000
- idle  out  1  high while state is IDLE
- error_out  out  1  high while state is ERROR

## Operation
- **Reset** (reset_L low, asynchronous):
  - state=RESET.
  - in_pop, out_push, out_data, full_threshold, empty_threshold, idle and error_out are all 0.
  - Round-robin pointer = 3, so the first grant goes to FIFO 0.
  - In-flight pipeline is cleared.
- **RESET:** moves to INIT on the first rising edge after reset_L goes high.
- **INIT:** thresholds capture umbral_full_in and umbral_empty_in on every edge while init=1. When init=0, the block goes to IDLE and the thresholds hold.
- **IDLE:**
  - init=1 → INIT. This has priority.
  - Otherwise, if any in_empty bit is 0 → ACTIVE.
- **ACTIVE:**
  - A requester i is eligible when in_empty[i]=0 and i was not popped in the current cycle.
  - A pop is allowed only when out_almost_full == 4'b0000 (conservative; destination is unknown before the read).
  - Grant rule: the first eligible index searching circularly from pointer+1. The pointer updates to the granted index.
  - in_pop[g] is high for exactly one cycle per grant. At most one pop per cycle.
  - Return to IDLE when in_empty == 4'b1111, no pop is asserted, and the pipeline is empty.
- **ERROR:**
  - Entered from INIT, IDLE or ACTIVE when any fifo_error bit is 1. This has priority over every other transition.
  - Sticky until reset_L is low.
  - in_pop and out_push are forced to 0, and in-flight words are dropped.
- **Routing:**
  - out_data = in_data_g, captured in full.
  - out_push = one-hot of in_data_g[WORD_SIZE-1:WORD_SIZE-2].
  - Data is never modified.

## Timing
- **Pop to push:** in_pop[g] high in cycle C; in_data_g valid in C+1; out_push and out_data registered high in C+2. Fixed 2-cycle latency.
- **Throughput:**
  - With two or more eligible requesters: 1 word/cycle.
  - With a single requester: 1 word every 2 cycles, because it is excluded from the cycle right after its own pop while in_empty updates.
- **Back-pressure:**
  - out_almost_full rising stops new pops from the next edge.
  - Up to 2 in-flight words still complete. This is why the almost-full threshold must be ≤ MEM_SIZE-2.
- **init** is honored only in INIT or IDLE. In ACTIVE it is ignored until the block returns to IDLE.
- **Reset mid-operation:** outputs clear immediately (asynchronously) and in-flight words are lost.
- The round-robin pointer wraps from 3 to 0.

## Test plan
- **Reset:**
  - Stimulus: hold reset_L=0 with random inputs.
  - Required: state=00001, all outputs 0.
  - Release reset with init=0 → state=00010 at edge 1, 00100 at edge 2.
- **Threshold programming:**
  - Stimulus: init=1, umbral_full_in=2, umbral_empty_in=1 for 2 cycles, then init=0.
  - Required: full_threshold=2, empty_threshold=1, state=IDLE, idle=1. Values hold when the inputs change afterwards.
- **Single requester:**
  - Stimulus: in_empty=4'b1110, in_data0=6'b100101.
  - Required: in_pop=0001 for 1 cycle, out_push=0100 and out_data=6'b100101 two cycles later, and no pop in the cycle right after the pop.
- **Round-robin:**
  - Stimulus: in_empty=0000 throughout.
  - Required: pops in the order 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- **Back-pressure:**
  - Stimulus: all inputs non-empty, then assert out_almost_full[2]=1 at cycle C.
  - Required: in_pop=0000 from C+1, at most 2 further out_push pulses, and popping resumes one cycle after the flag clears.
- **Error:**
  - Stimulus: pulse fifo_error[5] for 1 cycle in ACTIVE.
  - Required: state=10000, error_out=1, in_pop=out_push=0 while in ERROR. The block stays in ERROR until reset_L=0.

Source files
------------

// File: rtl/fifo_arbiter_ctrl_if.sv
// rtl/fifo_arbiter_ctrl_if.sv - FIFO-side bus between the arbiter controller and its FIFOs
//
// Purpose: bundles the signals exchanged with the four input FIFOs and the
// four output FIFOs.
// Signals:
//   in_empty[3:0]         empty flags of input FIFOs 0..3
//   in_data0..in_data3    read data of input FIFOs, valid the cycle after a pop
//   in_pop[3:0]           one-hot-or-zero pop strobe to the input FIFOs
//   out_almost_full[3:0]  almost-full flags of output FIFOs 0..3
//   out_push[3:0]         one-hot-or-zero push strobe to the output FIFOs
//   out_data              word presented together with out_push
// Modports: master = controller side, slave = FIFO side.

interface fifo_arbiter_ctrl_if #(
   parameter int WORD_SIZE = 6
);
   logic [3:0]           in_empty;
   logic [WORD_SIZE-1:0] in_data0;
   logic [WORD_SIZE-1:0] in_data1;
   logic [WORD_SIZE-1:0] in_data2;
   logic [WORD_SIZE-1:0] in_data3;
   logic [3:0]           in_pop;
   logic [3:0]           out_almost_full;
   logic [3:0]           out_push;
   logic [WORD_SIZE-1:0] out_data;

   modport master (
      input  in_empty, in_data0, in_data1, in_data2, in_data3, out_almost_full,
      output in_pop, out_push, out_data
   );

   modport slave (
      output in_empty, in_data0, in_data1, in_data2, in_data3, out_almost_full,
      input  in_pop, out_push, out_data
   );
endinterface

// File: rtl/fifo_arbiter_ctrl.sv
// rtl/fifo_arbiter_ctrl.sv - round-robin arbiter and router for four input and four output FIFOs
//
// Purpose: programs FIFO thresholds, pops one word at a time from a non-empty
// input FIFO in round-robin order, and pushes the word into the output FIFO
// named by its two MSBs. Halts permanently (until reset) on any FIFO error.
// Ports:
//   clk, reset_L                  clock, asynchronous active-low reset
//   init                          request threshold programming
//   umbral_full_in/empty_in       thresholds to program
//   fifo_error[7:0]               [3:0] input FIFO errors, [7:4] output FIFO errors
//   full_threshold/empty_threshold  programmed thresholds to all FIFOs
//   state[4:0], idle, error_out   one-hot state and status flags
//   fifo                          FIFO-side bus (master modport)

module fifo_arbiter_ctrl #(
   parameter int WORD_SIZE = 6,
   parameter int PTR_L     = 5,
   parameter int MEM_SIZE  = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              init,
   input  logic [PTR_L-1:0]  umbral_full_in,
   input  logic [PTR_L-1:0]  umbral_empty_in,
   input  logic [7:0]        fifo_error,
   output logic [PTR_L-1:0]  full_threshold,
   output logic [PTR_L-1:0]  empty_threshold,
   output logic [4:0]        state,
   output logic              idle,
   output logic              error_out,
   fifo_arbiter_ctrl_if.master fifo
);

   localparam logic [4:0] S_RESET  = 5'b00001;
   localparam logic [4:0] S_INIT   = 5'b00010;
   localparam logic [4:0] S_IDLE   = 5'b00100;
   localparam logic [4:0] S_ACTIVE = 5'b01000;
   localparam logic [4:0] S_ERROR  = 5'b10000;

   // Two words can still land after almost-full is seen, so a FIFO needs
   // room for at least that margin plus one.
   if (MEM_SIZE < 3) begin : g_mem_size_check
      $error("fifo_arbiter_ctrl: MEM_SIZE must be at least 3");
   end

   logic [4:0]           state_next;
   logic [1:0]           ptr;
   logic [3:0]           pop_q;       // which FIFO was popped last cycle; its data is valid now
   logic [3:0]           eligible;
   logic [3:0]           grant;
   logic [1:0]           gidx;
   logic [1:0]           idx;
   logic                 pop_en;
   logic [WORD_SIZE-1:0] sel_data;
   logic [1:0]           dst;
   logic [3:0]           push_next;

   assign idle      = (state == S_IDLE);
   assign error_out = (state == S_ERROR);

   // Destination is unknown before the read, so any almost-full blocks all pops.
   assign pop_en = (state == S_ACTIVE) && (fifo.out_almost_full == 4'b0000);

   // A FIFO popped this cycle is skipped: its in_empty flag has not updated yet.
   always_comb begin
      eligible = ~fifo.in_empty & ~fifo.in_pop;
      grant    = 4'b0000;
      gidx     = ptr;
      idx      = ptr;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (grant == 4'b0000 && eligible[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      case (pop_q)
         4'b0001: sel_data = fifo.in_data0;
         4'b0010: sel_data = fifo.in_data1;
         4'b0100: sel_data = fifo.in_data2;
         4'b1000: sel_data = fifo.in_data3;
         default: sel_data = '0;
      endcase
   end

   assign dst       = sel_data[WORD_SIZE-1 -: 2];
   assign push_next = (pop_q != 4'b0000) ? (4'b0001 << dst) : 4'b0000;

   always_comb begin
      state_next = state;
      case (state)
         S_RESET:  state_next = S_INIT;
         S_INIT:   state_next = init ? S_INIT : S_IDLE;
         S_IDLE: begin
            if (init)
               state_next = S_INIT;
            else if (fifo.in_empty != 4'b1111)
               state_next = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (fifo.in_empty == 4'b1111 && fifo.in_pop == 4'b0000 && pop_q == 4'b0000)
               state_next = S_IDLE;
         end
         S_ERROR:  state_next = S_ERROR;
         default:  state_next = S_RESET;
      endcase
      if ((fifo_error != 8'h00) &&
          (state == S_INIT || state == S_IDLE || state == S_ACTIVE))
         state_next = S_ERROR;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state           <= S_RESET;
         ptr             <= 2'd3;
         pop_q           <= 4'b0000;
         full_threshold  <= '0;
         empty_threshold <= '0;
         fifo.in_pop     <= 4'b0000;
         fifo.out_push   <= 4'b0000;
         fifo.out_data   <= '0;
      end else begin
         state <= state_next;
         if (state == S_INIT && init) begin
            full_threshold  <= umbral_full_in;
            empty_threshold <= umbral_empty_in;
         end
         if (state_next == S_ERROR) begin
            fifo.in_pop   <= 4'b0000;
            fifo.out_push <= 4'b0000;
            pop_q         <= 4'b0000;
         end else begin
            fifo.in_pop <= pop_en ? grant : 4'b0000;
            if (pop_en && grant != 4'b0000)
               ptr <= gidx;
            pop_q         <= fifo.in_pop;
            fifo.out_push <= push_next;
            if (pop_q != 4'b0000)
               fifo.out_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_fifo_arbiter_ctrl.sv
// tb/tb_fifo_arbiter_ctrl.sv - directed self-checking bench for fifo_arbiter_ctrl

module tb_fifo_arbiter_ctrl;

   logic       clk;
   logic       reset_L;
   logic       init;
   logic [4:0] umbral_full_in;
   logic [4:0] umbral_empty_in;
   logic [7:0] fifo_error;
   logic [4:0] full_threshold;
   logic [4:0] empty_threshold;
   logic [4:0] state;
   logic       idle;
   logic       error_out;

   int checks;
   int errors;
   int push_count;

   fifo_arbiter_ctrl_if #(.WORD_SIZE(6)) fifo_bus ();

   fifo_arbiter_ctrl #(.WORD_SIZE(6), .PTR_L(5), .MEM_SIZE(4)) dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .init            (init),
      .umbral_full_in  (umbral_full_in),
      .umbral_empty_in (umbral_empty_in),
      .fifo_error      (fifo_error),
      .full_threshold  (full_threshold),
      .empty_threshold (empty_threshold),
      .state           (state),
      .idle            (idle),
      .error_out       (error_out),
      .fifo            (fifo_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      push_count = 0;

      // Reset held with random inputs
      reset_L                  = 1'b0;
      init                     = 1'($urandom);
      umbral_full_in           = 5'($urandom);
      umbral_empty_in          = 5'($urandom);
      fifo_error               = 8'($urandom);
      fifo_bus.in_empty        = 4'($urandom);
      fifo_bus.in_data0        = 6'($urandom);
      fifo_bus.in_data1        = 6'($urandom);
      fifo_bus.in_data2        = 6'($urandom);
      fifo_bus.in_data3        = 6'($urandom);
      fifo_bus.out_almost_full = 4'($urandom);
      tick();
      tick();
      check("rst_state", 32'(state), 32'h01);
      check("rst_in_pop", 32'(fifo_bus.in_pop), 32'h0);
      check("rst_out_push", 32'(fifo_bus.out_push), 32'h0);
      check("rst_out_data", 32'(fifo_bus.out_data), 32'h0);
      check("rst_full_thr", 32'(full_threshold), 32'h0);
      check("rst_empty_thr", 32'(empty_threshold), 32'h0);
      check("rst_idle", 32'(idle), 32'h0);
      check("rst_error_out", 32'(error_out), 32'h0);

      // Release reset with quiet inputs
      init                     = 1'b0;
      fifo_error               = 8'h00;
      fifo_bus.in_empty        = 4'b1111;
      fifo_bus.out_almost_full = 4'b0000;
      reset_L                  = 1'b1;
      tick();
      check("rel_edge1_state", 32'(state), 32'h02);
      tick();
      check("rel_edge2_state", 32'(state), 32'h04);
      check("rel_edge2_idle", 32'(idle), 32'h1);

      // Threshold programming: two cycles of init, then hold
      init            = 1'b1;
      umbral_full_in  = 5'd2;
      umbral_empty_in = 5'd1;
      tick();
      tick();
      init            = 1'b0;
      umbral_full_in  = 5'd7;
      umbral_empty_in = 5'd3;
      tick();
      check("thr_full", 32'(full_threshold), 32'd2);
      check("thr_empty", 32'(empty_threshold), 32'd1);
      check("thr_state", 32'(state), 32'h04);
      check("thr_idle", 32'(idle), 32'h1);
      tick();
      check("thr_full_hold", 32'(full_threshold), 32'd2);
      check("thr_empty_hold", 32'(empty_threshold), 32'd1);

      // Single requester on FIFO 0, word routed to output FIFO 2
      fifo_bus.in_empty = 4'b1110;
      fifo_bus.in_data0 = 6'b100101;
      tick();
      check("single_active", 32'(state), 32'h08);
      check("single_no_pop_yet", 32'(fifo_bus.in_pop), 32'h0);
      tick();
      check("single_pop", 32'(fifo_bus.in_pop), 32'b0001);
      tick();
      check("single_gap_pop", 32'(fifo_bus.in_pop), 32'b0000);
      check("single_gap_push", 32'(fifo_bus.out_push), 32'b0000);
      fifo_bus.in_empty = 4'b1111;
      tick();
      check("single_push", 32'(fifo_bus.out_push), 32'b0100);
      check("single_data", 32'(fifo_bus.out_data), 32'b100101);
      check("single_no_pop", 32'(fifo_bus.in_pop), 32'b0000);
      tick();
      check("single_push_done", 32'(fifo_bus.out_push), 32'b0000);
      check("single_back_idle", 32'(state), 32'h04);

      // Fresh reset so the round-robin pointer starts at 3
      reset_L = 1'b0;
      tick();
      reset_L = 1'b1;
      tick();
      tick();
      check("rr_idle", 32'(state), 32'h04);

      // Round-robin with all inputs non-empty
      fifo_bus.in_data0 = 6'b000001;
      fifo_bus.in_data1 = 6'b010010;
      fifo_bus.in_data2 = 6'b100011;
      fifo_bus.in_data3 = 6'b110100;
      fifo_bus.in_empty = 4'b0000;
      tick();
      check("rr_active", 32'(state), 32'h08);
      tick();
      check("rr_pop0", 32'(fifo_bus.in_pop), 32'b0001);
      tick();
      check("rr_pop1", 32'(fifo_bus.in_pop), 32'b0010);
      tick();
      check("rr_pop2", 32'(fifo_bus.in_pop), 32'b0100);
      check("rr_push0", 32'(fifo_bus.out_push), 32'b0001);
      check("rr_data0", 32'(fifo_bus.out_data), 32'b000001);
      tick();
      check("rr_pop3", 32'(fifo_bus.in_pop), 32'b1000);
      check("rr_push1", 32'(fifo_bus.out_push), 32'b0010);
      check("rr_data1", 32'(fifo_bus.out_data), 32'b010010);
      tick();
      check("rr_pop_wrap", 32'(fifo_bus.in_pop), 32'b0001);
      check("rr_push2", 32'(fifo_bus.out_push), 32'b0100);

      // Back-pressure from output FIFO 2
      fifo_bus.out_almost_full = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_no_pop", 32'(fifo_bus.in_pop), 32'b0000);
         if (fifo_bus.out_push != 4'b0000)
            push_count++;
      end
      check("bp_inflight_pushes", 32'(push_count), 32'd2);
      fifo_bus.out_almost_full = 4'b0000;
      tick();
      check("bp_resume_pop", 32'(fifo_bus.in_pop), 32'b0010);

      // Error pulse on output FIFO 1 while active
      fifo_error = 8'h20;
      tick();
      check("err_state", 32'(state), 32'h10);
      check("err_flag", 32'(error_out), 32'h1);
      check("err_in_pop", 32'(fifo_bus.in_pop), 32'b0000);
      check("err_out_push", 32'(fifo_bus.out_push), 32'b0000);
      fifo_error = 8'h00;
      init       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("err_sticky_state", 32'(state), 32'h10);
         check("err_sticky_pop", 32'(fifo_bus.in_pop), 32'b0000);
         check("err_sticky_push", 32'(fifo_bus.out_push), 32'b0000);
      end

      // Asynchronous reset leaves ERROR without a clock edge
      @(negedge clk);
      reset_L = 1'b0;
      #1;
      check("async_rst_state", 32'(state), 32'h01);
      check("async_rst_error_out", 32'(error_out), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
